// File: rtl/ccip_mem_responder_pkg.sv
// Shared types for the CCI-P host-memory responder: a trimmed CCI-P request/response
// bundle, queue sizing constants and the per-channel queue entry formats.
package ccip_mem_responder_pkg;

    localparam int MEM_ADDR_BITS    = 10;
    localparam int QUEUE_DEPTH_BITS = 5;
    localparam int ALMFULL_SLACK    = 4;
    localparam int QUEUE_DEPTH      = 2 ** QUEUE_DEPTH_BITS;
    localparam int ALMFULL_THRESH   = QUEUE_DEPTH - ALMFULL_SLACK;

    typedef enum logic [1:0] {
        eCL_LEN_1 = 2'b00,
        eCL_LEN_2 = 2'b01,
        eCL_LEN_4 = 2'b11
    } t_ccip_clLen;

    typedef enum logic [3:0] {
        eRSP_RDLINE = 4'h0,
        eRSP_WRLINE = 4'h1
    } t_ccip_rspType;

    typedef struct packed {
        t_ccip_clLen  cl_len;
        logic [41:0]  address;
        logic [15:0]  mdata;
    } t_ccip_c0_ReqMemHdr;

    typedef struct packed {
        logic         sop;
        t_ccip_clLen  cl_len;
        logic [41:0]  address;
        logic [15:0]  mdata;
    } t_ccip_c1_ReqMemHdr;

    typedef struct packed {
        t_ccip_c0_ReqMemHdr hdr;
        logic               valid;
    } t_if_ccip_c0_Tx;

    typedef struct packed {
        t_ccip_c1_ReqMemHdr hdr;
        logic [511:0]       data;
        logic               valid;
    } t_if_ccip_c1_Tx;

    typedef struct packed {
        logic         mmioRdValid;
        logic [63:0]  data;
    } t_if_ccip_c2_Tx;

    typedef struct packed {
        t_if_ccip_c0_Tx c0;
        t_if_ccip_c1_Tx c1;
        t_if_ccip_c2_Tx c2;
    } t_if_ccip_Tx;

    typedef struct packed {
        t_ccip_rspType resp_type;
        logic [1:0]    cl_num;
        logic [15:0]   mdata;
    } t_ccip_c0_RspMemHdr;

    typedef struct packed {
        t_ccip_rspType resp_type;
        logic [15:0]   mdata;
    } t_ccip_c1_RspMemHdr;

    typedef struct packed {
        t_ccip_c0_RspMemHdr hdr;
        logic [511:0]       data;
        logic               rspValid;
        logic               mmioRdValid;
        logic               mmioWrValid;
    } t_if_ccip_c0_Rx;

    typedef struct packed {
        t_ccip_c1_RspMemHdr hdr;
        logic               rspValid;
    } t_if_ccip_c1_Rx;

    typedef struct packed {
        logic           c0TxAlmFull;
        logic           c1TxAlmFull;
        t_if_ccip_c0_Rx c0;
        t_if_ccip_c1_Rx c1;
    } t_if_ccip_Rx;

    typedef struct packed {
        logic [15:0]              mdata;
        logic [MEM_ADDR_BITS-1:0] addr;
    } t_rsp_entry;

    typedef struct packed {
        logic [15:0] mdata;
    } t_wr_entry;

endpackage

// File: rtl/ccip_mem_responder_if.sv
// CCI-P request/response bundle between an AFU-side master and the memory responder.
// Requests are accepted in the cycle their valid is high; there is no ready, AlmFull throttles.
interface ccip_mem_responder_if;
    import ccip_mem_responder_pkg::*;

    t_if_ccip_Tx af2cp_sTx;
    t_if_ccip_Rx cp2af_sRx;

    modport master (output af2cp_sTx, input cp2af_sRx);
    modport slave  (input af2cp_sTx, output cp2af_sRx);
endinterface

// File: rtl/ccip_mem_responder_resp_channel.sv
// One response channel: fixed-latency shift pipeline feeding a response FIFO, with the
// in-flight counter that drives AlmFull and rejects requests once the channel is full.
module ccip_mem_responder_resp_channel
    import ccip_mem_responder_pkg::*;
#(
    parameter int LATENCY = 1,
    parameter int W       = 16
) (
    input  logic         userclk,
    input  logic         reset,
    input  logic         req_valid_i,
    input  logic [W-1:0] req_entry_i,
    input  logic         pop_en_i,
    output logic         accept_o,
    output logic         overflow_o,
    output logic         issue_o,
    output logic [W-1:0] issue_entry_o,
    output logic         almfull_o
);
    localparam logic [QUEUE_DEPTH_BITS:0] DEPTH_C  = (QUEUE_DEPTH_BITS + 1)'(QUEUE_DEPTH);
    localparam logic [QUEUE_DEPTH_BITS:0] THRESH_C = (QUEUE_DEPTH_BITS + 1)'(ALMFULL_THRESH);

    logic [QUEUE_DEPTH_BITS:0]   count_q, count_d;
    logic [QUEUE_DEPTH_BITS:0]   fill_q, fill_d;
    logic [QUEUE_DEPTH_BITS-1:0] wr_ptr_q, rd_ptr_q;
    logic [W-1:0]                fifo_mem [QUEUE_DEPTH];
    logic                        almfull_q;
    logic                        push_valid;
    logic [W-1:0]                push_entry;

    assign accept_o      = req_valid_i && (count_q != DEPTH_C);
    assign overflow_o    = req_valid_i && (count_q == DEPTH_C);
    assign issue_o       = (fill_q != '0) && pop_en_i;
    assign issue_entry_o = fifo_mem[rd_ptr_q];
    assign almfull_o     = almfull_q;

    // The FIFO write is the last latency stage, so the pipeline carries LATENCY-1 registers.
    generate
        if (LATENCY == 1) begin : g_direct
            assign push_valid = accept_o;
            assign push_entry = req_entry_i;
        end else begin : g_pipe
            logic [LATENCY-2:0] pv_q;
            logic [W-1:0]       pe_q [LATENCY-1];
            always_ff @(posedge userclk) begin
                if (reset) begin
                    pv_q <= '0;
                end else begin
                    pv_q[0] <= accept_o;
                    for (int i = 1; i < LATENCY - 1; i++) pv_q[i] <= pv_q[i-1];
                end
                pe_q[0] <= req_entry_i;
                for (int i = 1; i < LATENCY - 1; i++) pe_q[i] <= pe_q[i-1];
            end
            assign push_valid = pv_q[LATENCY-2];
            assign push_entry = pe_q[LATENCY-2];
        end
    endgenerate

    always_comb begin
        count_d = count_q;
        if (accept_o && !issue_o)      count_d = count_q + 1'b1;
        else if (!accept_o && issue_o) count_d = count_q - 1'b1;
        fill_d = fill_q;
        if (push_valid && !issue_o)      fill_d = fill_q + 1'b1;
        else if (!push_valid && issue_o) fill_d = fill_q - 1'b1;
    end

    always_ff @(posedge userclk) begin
        if (push_valid) fifo_mem[wr_ptr_q] <= push_entry;
    end

    always_ff @(posedge userclk) begin
        if (reset) begin
            count_q   <= '0;
            fill_q    <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            almfull_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            fill_q    <= fill_d;
            almfull_q <= (count_d >= THRESH_C);
            if (push_valid) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (issue_o)    rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end
endmodule

// File: rtl/ccip_mem_responder.sv
// CCI-P host-memory endpoint: services c0 reads / c1 writes from a local line memory and
// returns responses with mdata echoed, so instance tags in mdata route back through the mux.
module ccip_mem_responder
    import ccip_mem_responder_pkg::*;
#(
    parameter int READ_LATENCY  = 8,
    parameter int WRITE_LATENCY = 4
) (
    input  logic                userclk,
    input  logic                reset,
    ccip_mem_responder_if.slave ccip,
    input  logic                hold_rsp,
    output logic                err_overflow,
    output logic                err_multiline,
    output logic [31:0]         rd_count,
    output logic [31:0]         wr_count
);
    t_ccip_c0_ReqMemHdr c0_hdr;
    t_ccip_c1_ReqMemHdr c1_hdr;
    t_rsp_entry         rd_req_entry, rd_issue_entry;
    t_wr_entry          wr_req_entry, wr_issue_entry;
    logic [$bits(t_rsp_entry)-1:0] rd_issue_bits;
    logic [$bits(t_wr_entry)-1:0]  wr_issue_bits;
    logic rd_accept, rd_ovf, rd_issue, rd_almfull;
    logic wr_accept, wr_ovf, wr_issue, wr_almfull;
    logic multiline;
    logic unused_bits;

    logic [511:0] mem [2**MEM_ADDR_BITS];

    logic         c0_valid_q, c1_valid_q;
    logic [15:0]  c0_mdata_q, c1_mdata_q;
    logic [511:0] c0_data_q;
    logic [31:0]  rd_count_q, wr_count_q;
    logic         err_ovf_q, err_ml_q;

    assign c0_hdr         = ccip.af2cp_sTx.c0.hdr;
    assign c1_hdr         = ccip.af2cp_sTx.c1.hdr;
    assign rd_req_entry   = '{mdata: c0_hdr.mdata, addr: c0_hdr.address[MEM_ADDR_BITS-1:0]};
    assign wr_req_entry   = '{mdata: c1_hdr.mdata};
    assign rd_issue_entry = rd_issue_bits;
    assign wr_issue_entry = wr_issue_bits;
    assign multiline = (ccip.af2cp_sTx.c0.valid && (c0_hdr.cl_len != eCL_LEN_1)) ||
                       (ccip.af2cp_sTx.c1.valid && (c1_hdr.cl_len != eCL_LEN_1));
    assign unused_bits = ^{ccip.af2cp_sTx.c2, c0_hdr.address[41:MEM_ADDR_BITS],
                           c1_hdr.address[41:MEM_ADDR_BITS], c1_hdr.sop, rd_accept};

    ccip_mem_responder_resp_channel #(.LATENCY(READ_LATENCY), .W($bits(t_rsp_entry))) u_rd_chan (
        .userclk(userclk), .reset(reset),
        .req_valid_i(ccip.af2cp_sTx.c0.valid), .req_entry_i(rd_req_entry), .pop_en_i(!hold_rsp),
        .accept_o(rd_accept), .overflow_o(rd_ovf), .issue_o(rd_issue),
        .issue_entry_o(rd_issue_bits), .almfull_o(rd_almfull)
    );

    ccip_mem_responder_resp_channel #(.LATENCY(WRITE_LATENCY), .W($bits(t_wr_entry))) u_wr_chan (
        .userclk(userclk), .reset(reset),
        .req_valid_i(ccip.af2cp_sTx.c1.valid), .req_entry_i(wr_req_entry), .pop_en_i(!hold_rsp),
        .accept_o(wr_accept), .overflow_o(wr_ovf), .issue_o(wr_issue),
        .issue_entry_o(wr_issue_bits), .almfull_o(wr_almfull)
    );

    // Memory is deliberately not reset so data survives a responder reset.
    always_ff @(posedge userclk) begin
        if (wr_accept) mem[c1_hdr.address[MEM_ADDR_BITS-1:0]] <= ccip.af2cp_sTx.c1.data;
    end

    always_ff @(posedge userclk) begin
        if (reset) begin
            c0_valid_q <= 1'b0;
            c1_valid_q <= 1'b0;
            c0_mdata_q <= '0;
            c1_mdata_q <= '0;
            c0_data_q  <= '0;
            rd_count_q <= '0;
            wr_count_q <= '0;
            err_ovf_q  <= 1'b0;
            err_ml_q   <= 1'b0;
        end else begin
            c0_valid_q <= rd_issue;
            c1_valid_q <= wr_issue;
            if (rd_issue) begin
                c0_mdata_q <= rd_issue_entry.mdata;
                c0_data_q  <= mem[rd_issue_entry.addr];
                rd_count_q <= rd_count_q + 32'd1;
            end
            if (wr_issue) begin
                c1_mdata_q <= wr_issue_entry.mdata;
                wr_count_q <= wr_count_q + 32'd1;
            end
            err_ovf_q <= err_ovf_q | rd_ovf | wr_ovf;
            err_ml_q  <= err_ml_q | multiline;
        end
    end

    // Response type is gated by valid so the whole bundle reads as zero while idle/in reset.
    always_comb begin
        ccip.cp2af_sRx                  = '0;
        ccip.cp2af_sRx.c0TxAlmFull      = rd_almfull;
        ccip.cp2af_sRx.c1TxAlmFull      = wr_almfull;
        ccip.cp2af_sRx.c0.rspValid      = c0_valid_q;
        ccip.cp2af_sRx.c0.hdr.resp_type = eRSP_RDLINE;
        ccip.cp2af_sRx.c0.hdr.mdata     = c0_mdata_q;
        ccip.cp2af_sRx.c0.data          = c0_data_q;
        ccip.cp2af_sRx.c1.rspValid      = c1_valid_q;
        ccip.cp2af_sRx.c1.hdr.resp_type = c1_valid_q ? eRSP_WRLINE : eRSP_RDLINE;
        ccip.cp2af_sRx.c1.hdr.mdata     = c1_mdata_q;
    end

    assign err_overflow  = err_ovf_q;
    assign err_multiline = err_ml_q;
    assign rd_count      = rd_count_q;
    assign wr_count      = wr_count_q;
endmodule

// File: doc/ccip_mem_responder.md
Name: ccip_mem_responder

Overview:
- CCI-P responder (host-memory endpoint) for the multi-instance request mux/demux layer.
- Accepts c0 read requests and c1 write requests on a t_if_ccip_Tx bundle.
- Services them from a local line memory and returns read/write responses on a t_if_ccip_Rx bundle, with mdata echoed unchanged so instance tags in mdata[15:14] route back correctly.
- Drives c0TxAlmFull/c1TxAlmFull from internal occupancy; used as the bench/emulation endpoint behind the arbiter.

Parameters:
- MEM_ADDR_BITS, 10: local memory holds 2^MEM_ADDR_BITS 512-bit lines; request address is taken modulo this size.
- QUEUE_DEPTH_BITS, 5: per-channel in-flight capacity 2^QUEUE_DEPTH_BITS, covering latency pipeline plus response FIFO.
- READ_LATENCY, 8: cycles from read-request acceptance to earliest response, minimum 1.
- WRITE_LATENCY, 4: cycles from write-request acceptance to earliest response, minimum 1.
- ALMFULL_SLACK, 4: AlmFull asserts when in-flight count >= 2^QUEUE_DEPTH_BITS - ALMFULL_SLACK.

Ports:
- userclk  in  1  clock
- reset  in  1  synchronous, active-high
- af2cp_sTx  in  $bits(t_if_ccip_Tx)  requests; c0 = read, c1 = write, c2 ignored
- cp2af_sRx  out  $bits(t_if_ccip_Rx)  responses plus AlmFull; mmio fields tied 0
- hold_rsp  in  1  when 1, no responses are issued (backpressure emulation for test)
- err_overflow  out  1  sticky; a request arrived while its channel was at full capacity
- err_multiline  out  1  sticky; a request arrived with cl_len != eCL_LEN_1
- rd_count  out  32  number of read responses issued
- wr_count  out  32  number of write responses issued

Behaviour:
- Reset (synchronous, active-high on userclk): all outputs 0. This includes rspValid, AlmFull, error flags and counters. Pipelines, FIFOs and in-flight counts are cleared. Memory contents are preserved.
- Reset mid-operation: in-flight requests are discarded and no responses are issued for them.
- Acceptance: c0.valid or c1.valid in cycle t accepts the request in cycle t. Both channels may accept in the same cycle.
- Write commit: the memory at the write address is updated in cycle t (write-first at acceptance).
- Read sampling: memory is sampled when the read leaves the latency pipeline. Any write accepted in an earlier cycle is therefore visible.
- Latency pipeline: each channel has a READ_LATENCY / WRITE_LATENCY stage shift pipeline of {valid, mdata, addr}. Its output pushes into a per-channel response FIFO.
- Issue: each FIFO pops at most one entry per cycle when non-empty and hold_rsp = 0. The response is registered, so the total minimum latency is LATENCY + 1 cycles.
- Read response fields: c0.rspValid = 1, resp_type = eRSP_RDLINE, cl_num = 0, mdata echoed, data = line read.
- Write response fields: c1.rspValid = 1, resp_type = eRSP_WRLINE, mdata echoed.
- Response order: in order per channel. There is no ordering between channels.
- In-flight count (per channel): +1 on accept, -1 on issue; the same-cycle +1/-1 nets to 0. Width is QUEUE_DEPTH_BITS + 1.
- AlmFull: registered from the in-flight count; c0TxAlmFull for the read count, c1TxAlmFull for the write count.
- Full: a request arriving at count == 2^QUEUE_DEPTH_BITS is dropped (no memory write, no response) and err_overflow is set.
- Multi-line: a request with cl_len != eCL_LEN_1 is serviced as single-line and sets err_multiline. c1 sop is ignored.
- Counters: rd_count and wr_count increment on each issued response and wrap at 2^32.

Decomposition:
- Package ccip_mem_responder_pkg holds:
  - the localparams QUEUE_DEPTH and ALMFULL_THRESH;
  - the typedef t_rsp_entry {mdata[15:0], addr[MEM_ADDR_BITS-1:0]};
  - the typedef t_wr_entry {mdata}.
- One sub-module, resp_channel: latency shift pipeline + synchronous FIFO + in-flight counter + AlmFull/overflow logic. It is instantiated twice, once for reads and once for writes.
- Memory and response formatting live in the top.

Test Plan:
- Write 0xA5-pattern to addr 3 (mdata 0x4001), then read addr 3 (mdata 0x8002) -> c1 response with mdata 0x4001 at accept+5; c0 response with mdata 0x8002 and data 0xA5-pattern at accept+9; wr_count = 1, rd_count = 1.
- Same-cycle write addr 7 and read addr 7 -> read returns the new data; both channels respond independently.
- hold_rsp = 1 and 28 reads issued -> c0TxAlmFull rises after the 28th accept. With 32 accepted, the 33rd sets err_overflow and is never answered. Then hold_rsp = 0 -> exactly 32 in-order responses, and AlmFull drops once the count falls below 28.
- Reads to addr 2^MEM_ADDR_BITS + 5 and addr 5 -> identical data (wrap).
- Request with cl_len = eCL_LEN_2 -> one response issued; err_multiline = 1 and stays 1.
- Reset asserted with 6 reads in flight -> no further rspValid; outputs 0 the cycle after reset. Memory data written before reset still reads back after.
